// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg
// Shared types and constants for the three-port SDRAM arbiter.
//   arb_state_e  : arbiter FSM states
//   PORT_*       : port index constants (0 = CPU ifetch, 1 = CPU data, 2 = VGA)
//   sdram_cmd_t  : registered command (write, address, wdata, wmask)
//   port_onehot  : converts a port index into a one-hot port vector
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_READ = 2'd2
  } arb_state_e;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] PORT_IFETCH = 2'd0;
  localparam logic [1:0] PORT_DATA   = 2'd1;
  localparam logic [1:0] PORT_VGA    = 2'd2;

  // The address field is sized for the widest supported bus; the top keeps
  // only the low ADDR_W bits.
  localparam int CMD_ADDR_W = 32;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] address;
    logic [31:0]           wdata;
    logic [3:0]            wmask;
  } sdram_cmd_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] port);
    return NUM_PORTS'(3'b001 << port);
  endfunction

endpackage

// File: rtl/sdram_arb_select.sv
// sdram_arb_select
// Combinational winner selection and starvation bookkeeping.
// Ports:
//   req_valid_i      : per-port request valid
//   rr_ptr_i         : CPU round-robin pointer (0 = port 0 preferred, 1 = port 1)
//   starve_count_i   : consecutive VGA grants made while a CPU port waited
//   grant_o          : some port is requesting
//   winner_o         : index of the selected port
//   rr_ptr_o         : pointer value to load if this grant is taken
//   starve_count_o   : starvation count to load if this grant is taken
module sdram_arb_select
  import sdram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic [NUM_PORTS-1:0] req_valid_i,
  input  logic                 rr_ptr_i,
  input  logic [CNT_W-1:0]     starve_count_i,
  output logic                 grant_o,
  output logic [1:0]           winner_o,
  output logic                 rr_ptr_o,
  output logic [CNT_W-1:0]     starve_count_o
);

  logic       cpuAny;
  logic       cpuStarved;
  logic [1:0] cpuWinner;

  // VGA normally wins, but once it has been granted STARVE_MAX times in a
  // row over a waiting CPU port, the CPU round-robin winner gets one turn.
  // The last granted CPU port is demoted by pointing rr at the other port.
  always_comb begin
    cpuAny         = req_valid_i[PORT_IFETCH] | req_valid_i[PORT_DATA];
    cpuStarved     = cpuAny && (starve_count_i == CNT_W'(STARVE_MAX));
    grant_o        = |req_valid_i;
    rr_ptr_o       = rr_ptr_i;
    starve_count_o = starve_count_i;

    if (req_valid_i[PORT_IFETCH] && req_valid_i[PORT_DATA]) begin
      cpuWinner = rr_ptr_i ? PORT_DATA : PORT_IFETCH;
    end else if (req_valid_i[PORT_DATA]) begin
      cpuWinner = PORT_DATA;
    end else begin
      cpuWinner = PORT_IFETCH;
    end
    winner_o = cpuWinner;

    if (req_valid_i[PORT_VGA] && !cpuStarved) begin
      winner_o = PORT_VGA;
      if (cpuAny && (starve_count_i != CNT_W'(STARVE_MAX))) begin
        starve_count_o = starve_count_i + CNT_W'(1);
      end
    end else if (cpuAny) begin
      rr_ptr_o       = (cpuWinner == PORT_IFETCH);
      starve_count_o = '0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Three-port arbiter in front of a single-command SDRAM controller.
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   req_valid/write/addr/wdata/wmask : per-port request (0 ifetch, 1 data, 2 VGA)
//   req_ready                    : one-hot, request captured this cycle
//   rsp_valid, rsp_rdata         : one-hot response pulse, shared read data
//   sdram_request + fields       : command to the controller, held until sdram_ready
//   sdram_ready                  : controller accepts the command
//   sdram_rvalid, sdram_rdata    : read data return
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 26,
  parameter int STARVE_MAX = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           req_valid,
  input  logic [NUM_PORTS-1:0]           req_write,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0][31:0]     req_wdata,
  input  logic [NUM_PORTS-1:0][3:0]      req_wmask,
  output logic [NUM_PORTS-1:0]           req_ready,
  output logic [NUM_PORTS-1:0]           rsp_valid,
  output logic [31:0]                    rsp_rdata,
  output logic                           sdram_request,
  output logic                           sdram_write,
  output logic [ADDR_W-1:0]              sdram_address,
  output logic [31:0]                    sdram_wdata,
  output logic [3:0]                     sdram_wmask,
  input  logic                           sdram_ready,
  input  logic                           sdram_rvalid,
  input  logic [31:0]                    sdram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e           state_q;
  sdram_cmd_t           cmd_q, cmd_d;
  logic [1:0]           owner_q;
  logic [NUM_PORTS-1:0] rsp_valid_q;
  logic [31:0]          rsp_rdata_q;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 rr_q, rr_d;
  logic                 grant;
  logic [1:0]           winner;
  logic                 unusedBits;

  sdram_arb_select #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_select (
    .req_valid_i    (req_valid),
    .rr_ptr_i       (rr_q),
    .starve_count_i (starve_q),
    .grant_o        (grant),
    .winner_o       (winner),
    .rr_ptr_o       (rr_d),
    .starve_count_o (starve_d)
  );

  // Word-aligned command for the winning port; byte offset bits are dropped.
  always_comb begin
    cmd_d         = '0;
    cmd_d.write   = req_write[winner];
    cmd_d.address = CMD_ADDR_W'({req_addr[winner][ADDR_W-1:2], 2'b00});
    cmd_d.wdata   = req_wdata[winner];
    cmd_d.wmask   = req_wmask[winner];
  end

  // Arbiter FSM: one transaction in flight. Responses are registered, so a
  // response pulse lands in the same cycle the FSM is back in IDLE and may
  // already grant the next request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      owner_q     <= PORT_IFETCH;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      starve_q    <= '0;
      rr_q        <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant) begin
            cmd_q    <= cmd_d;
            owner_q  <= winner;
            starve_q <= starve_d;
            rr_q     <= rr_d;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sdram_ready) begin
            if (cmd_q.write) begin
              rsp_valid_q <= port_onehot(owner_q);
              state_q     <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT_READ;
            end
          end
        end
        ST_WAIT_READ: begin
          if (sdram_rvalid) begin
            rsp_valid_q <= port_onehot(owner_q);
            rsp_rdata_q <= sdram_rdata;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // req_ready follows the registered state so it only ever marks the port
  // being captured by the IDLE grant this cycle.
  assign req_ready     = (state_q == ST_IDLE && grant) ? port_onehot(winner) : '0;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign sdram_request = (state_q == ST_ISSUE);
  assign sdram_write   = cmd_q.write;
  assign sdram_address = cmd_q.address[ADDR_W-1:0];
  assign sdram_wdata   = cmd_q.wdata;
  assign sdram_wmask   = cmd_q.wmask;

  assign unusedBits = ^{cmd_q.address, req_addr};

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Scoreboard bench: each grant pushes the expected response (port, data) and
// the response monitor pops and compares. An SDRAM model answers commands
// with configurable ready and read-data delays.
module tb_sdram_arbiter;

  localparam int ADDR_W = 26;

  typedef struct {
    int          port;
    bit          write;
    logic [31:0] data;
  } exp_t;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [2:0]             req_valid = '0;
  logic [2:0]             req_write = '0;
  logic [2:0][ADDR_W-1:0] req_addr  = '0;
  logic [2:0][31:0]       req_wdata = '0;
  logic [2:0][3:0]        req_wmask = '0;
  logic [2:0]             req_ready;
  logic [2:0]             rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   sdram_request;
  logic                   sdram_write;
  logic [ADDR_W-1:0]      sdram_address;
  logic [31:0]            sdram_wdata;
  logic [3:0]             sdram_wmask;
  logic                   sdram_ready  = 1'b0;
  logic                   sdram_rvalid = 1'b0;
  logic [31:0]            sdram_rdata  = '0;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycle       = 0;
  int   lastRvalidCycle = -100;
  int   lastAcceptCycle = -100;
  int   readyDelay  = 0;
  int   rvalidDelay = 1;
  bit   spuriousReq = 1'b0;
  exp_t sbQ[$];
  int   grantLog[$];
  logic [31:0] mem [logic [ADDR_W-1:0]];

  sdram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wmask     (req_wmask),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .sdram_request (sdram_request),
    .sdram_write   (sdram_write),
    .sdram_address (sdram_address),
    .sdram_wdata   (sdram_wdata),
    .sdram_wmask   (sdram_wmask),
    .sdram_ready   (sdram_ready),
    .sdram_rvalid  (sdram_rvalid),
    .sdram_rdata   (sdram_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] memData(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {6'h2A, a};
  endfunction

  task automatic applyReset();
    reset = 1'b1;
    sbQ.delete();
    grantLog.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Holds one request until captured, then records the expected response.
  task automatic applyStimulus(input int p, input bit wr, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wmask,
                               output int waitCycles);
    exp_t e;
    bit   granted = 1'b0;
    req_valid[p] = 1'b1;
    req_write[p] = wr;
    req_addr[p]  = addr;
    req_wdata[p] = wdata;
    req_wmask[p] = wmask;
    waitCycles   = 0;
    for (int i = 0; i < 300 && !granted; i++) begin
      @(negedge clock);
      if (req_ready[p]) begin
        granted = 1'b1;
        e.port  = p;
        e.write = wr;
        e.data  = memData(addr);
        sbQ.push_back(e);
      end else begin
        waitCycles++;
      end
    end
    if (!granted) checkOutput("grant_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic runStream(input int p, input int n, input bit wr, input logic [ADDR_W-1:0] base);
    int w;
    for (int i = 0; i < n; i++) begin
      applyStimulus(p, wr, base + ADDR_W'(4 * i), 32'h1000_0000 + i, 4'hF, w);
    end
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (sbQ.size() == 0 && !sdram_request) break;
      tick();
    end
    checkOutput(tag, sbQ.size(), 0);
    repeat (3) tick();
  endtask

  // SDRAM controller model: accepts after readyDelay cycles, returns read
  // data rvalidDelay cycles after acceptance.
  initial begin
    logic [ADDR_W-1:0] a;
    bit                w;
    forever begin
      tick();
      if (sdram_request) begin
        repeat (readyDelay) tick();
        sdram_ready = 1'b1;
        a = sdram_address;
        w = sdram_write;
        tick();
        sdram_ready = 1'b0;
        if (!w) begin
          repeat (rvalidDelay - 1) tick();
          sdram_rvalid = 1'b1;
          sdram_rdata  = memData(a);
          tick();
          sdram_rvalid = 1'b0;
        end
      end else if (spuriousReq) begin
        sdram_rvalid = 1'b1;
        sdram_rdata  = 32'h0BAD_F00D;
        tick();
        sdram_rvalid = 1'b0;
        wait (!spuriousReq);
      end
    end
  end

  // Grant and response monitor, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (req_ready !== 3'b000) begin
          checkOutput("ready_onehot", 64'($onehot(req_ready)), 64'd1);
          checkOutput("ready_owner", req_ready & ~req_valid, 3'b000);
          for (int i = 0; i < 3; i++) if (req_ready[i]) grantLog.push_back(i);
        end
        if (rsp_valid !== 3'b000) begin
          if (sbQ.size() == 0) begin
            checkOutput("rsp_unexpected", rsp_valid, 3'b000);
          end else begin
            e = sbQ.pop_front();
            checkOutput("rsp_port", rsp_valid, 3'b001 << e.port);
            if (e.write) begin
              checkOutput("wr_latency", cycle - lastAcceptCycle, 1);
            end else begin
              checkOutput("rsp_rdata", rsp_rdata, e.data);
              checkOutput("rd_latency", cycle - lastRvalidCycle, 1);
            end
          end
        end
      end
      if (sdram_request && sdram_ready) lastAcceptCycle = cycle;
      if (sdram_rvalid) lastRvalidCycle = cycle;
    end
  end

  initial begin
    int w;
    mem[26'h100] = 32'hDEAD_BEEF;
    tick();
    applyReset();

    // Reset state
    @(negedge clock);
    checkOutput("rst_req_ready", req_ready, 3'b000);
    checkOutput("rst_rsp_valid", rsp_valid, 3'b000);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_sdram_req", sdram_request, 1'b0);
    checkOutput("rst_cmd", {sdram_write, sdram_address, sdram_wdata, sdram_wmask}, '0);
    tick();

    // Single read from port 1
    readyDelay = 0;
    rvalidDelay = 5;
    applyStimulus(1, 1'b0, 26'h100, 32'h0, 4'h0, w);
    checkOutput("rd_grant_wait", w, 0);
    @(negedge clock);
    checkOutput("rd_sdram_req", sdram_request, 1'b1);
    checkOutput("rd_sdram_addr", sdram_address, 26'h100);
    checkOutput("rd_sdram_write", sdram_write, 1'b0);
    tick();
    waitDrain("rd_drain");
    checkOutput("rd_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // Spurious read strobe while idle
    spuriousReq = 1'b1;
    repeat (4) tick();
    spuriousReq = 1'b0;
    repeat (3) tick();
    checkOutput("spur_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // Write with a slow controller
    readyDelay = 3;
    applyStimulus(0, 1'b1, 26'h300, 32'hCAFE_F00D, 4'b0101, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput($sformatf("wr_hold_req%0d", i), sdram_request, 1'b1);
      checkOutput($sformatf("wr_hold_fields%0d", i),
                  {sdram_write, sdram_address, sdram_wdata, sdram_wmask},
                  {1'b1, 26'h300, 32'hCAFE_F00D, 4'b0101});
    end
    @(negedge clock);
    checkOutput("wr_req_drop", sdram_request, 1'b0);
    tick();
    waitDrain("wr_drain");
    readyDelay = 0;

    // CPU round robin
    applyReset();
    rvalidDelay = 2;
    fork
      runStream(0, 4, 1'b0, 26'h200);
      runStream(1, 4, 1'b1, 26'h280);
    join
    waitDrain("rr_drain");
    checkOutput("rr_count", grantLog.size(), 8);
    for (int i = 0; i < 8 && i < grantLog.size(); i++)
      checkOutput($sformatf("rr_grant%0d", i), grantLog[i], i % 2);

    // VGA priority with starvation relief
    applyReset();
    rvalidDelay = 1;
    fork
      runStream(2, 16, 1'b0, 26'h1000);
      runStream(0, 2, 1'b1, 26'h2000);
    join
    waitDrain("starve_drain");
    checkOutput("starve_count", grantLog.size(), 18);
    for (int i = 0; i < 18 && i < grantLog.size(); i++)
      checkOutput($sformatf("starve_grant%0d", i), grantLog[i], (i == 8 || i == 17) ? 0 : 2);

    // Reset during WAIT_READ, read data arrives after release
    applyReset();
    rvalidDelay = 5;
    applyStimulus(1, 1'b0, 26'h400, 32'h0, 4'h0, w);
    tick();
    reset = 1'b1;
    sbQ.delete();
    grantLog.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    @(negedge clock);
    checkOutput("rstw_sdram_req", sdram_request, 1'b0);
    checkOutput("rstw_rsp_valid", rsp_valid, 3'b000);
    tick();
    rvalidDelay = 2;
    applyStimulus(2, 1'b0, 26'h500, 32'h0, 4'h0, w);
    checkOutput("rstw_grant_wait", w, 0);
    waitDrain("rstw_drain");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
